// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - AXI4-Lite single-outstanding register access master
module axi_lite_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        FCLK_CLK0,
  input  logic        RST_N,
  // command side
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_write,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  input  logic [3:0]  i_cmd_wstrb,
  // response side
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_resp,
  output logic        o_rsp_timeout,
  // write address channel
  output logic [31:0] AXI_awaddr,
  output logic [2:0]  AXI_awprot,
  output logic        AXI_awvalid,
  input  logic        AXI_awready,
  // write data channel
  output logic [31:0] AXI_wdata,
  output logic [3:0]  AXI_wstrb,
  output logic        AXI_wvalid,
  input  logic        AXI_wready,
  // write response channel
  input  logic [1:0]  AXI_bresp,
  input  logic        AXI_bvalid,
  output logic        AXI_bready,
  // read address channel
  output logic [31:0] AXI_araddr,
  output logic [2:0]  AXI_arprot,
  output logic        AXI_arvalid,
  input  logic        AXI_arready,
  // read data channel
  input  logic [31:0] AXI_rdata,
  input  logic [1:0]  AXI_rresp,
  input  logic        AXI_rvalid,
  output logic        AXI_rready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [31:0] LP_LAST  = 32'(TIMEOUT_CYCLES - 32'd1);
  localparam logic        LP_TO_EN = (TIMEOUT_CYCLES != 32'd0);

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_b_done;
  logic        r_ar_done;
  logic [31:0] r_cnt;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_resp;
  logic        r_rsp_timeout;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_wr_done;
  logic        w_limit;

  // Channel valids/readies follow the state and per-channel done flags, so
  // they are all 0 in IDLE/RESP and drop the cycle after their own handshake.
  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_rsp_valid   = (r_state == S_RESP);
  assign AXI_awvalid   = (r_state == S_WRITE) && !r_aw_done;
  assign AXI_wvalid    = (r_state == S_WRITE) && !r_w_done;
  assign AXI_bready    = (r_state == S_WRITE);
  assign AXI_arvalid   = (r_state == S_READ) && !r_ar_done;
  assign AXI_rready    = (r_state == S_READ);

  assign AXI_awaddr    = r_addr;
  assign AXI_araddr    = r_addr;
  assign AXI_awprot    = 3'b000;
  assign AXI_arprot    = 3'b000;
  assign AXI_wdata     = r_wdata;
  assign AXI_wstrb     = r_wstrb;

  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_resp    = r_rsp_resp;
  assign o_rsp_timeout = r_rsp_timeout;

  assign w_aw_hs   = AXI_awvalid && AXI_awready;
  assign w_w_hs    = AXI_wvalid && AXI_wready;
  assign w_b_hs    = AXI_bready && AXI_bvalid;
  assign w_ar_hs   = AXI_arvalid && AXI_arready;
  // An R beat seen before the address has been accepted is not ours.
  assign w_r_hs    = AXI_rready && AXI_rvalid && (r_ar_done || w_ar_hs);
  assign w_wr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs) && (r_b_done || w_b_hs);
  assign w_limit   = LP_TO_EN && (r_cnt == LP_LAST);

  // State register.
  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; completion on the limit cycle takes priority over timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_cmd_valid) w_next = i_cmd_write ? S_WRITE : S_READ;
      S_WRITE: if (w_wr_done || w_limit) w_next = S_RESP;
      S_READ:  if (w_r_hs || w_limit) w_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command capture, handshake bookkeeping, timeout counter and response capture.
  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_wstrb       <= 4'd0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_b_done      <= 1'b0;
      r_ar_done     <= 1'b0;
      r_cnt         <= 32'd0;
      r_rsp_rdata   <= 32'd0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_addr        <= i_cmd_addr;
            r_wdata       <= i_cmd_wdata;
            r_wstrb       <= i_cmd_wstrb;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_b_done      <= 1'b0;
            r_ar_done     <= 1'b0;
            r_cnt         <= 32'd0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
          end
        end
        S_WRITE: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if (w_b_hs) begin
            r_b_done   <= 1'b1;
            r_rsp_resp <= AXI_bresp;
          end
          if (!w_wr_done && w_limit) begin
            r_rsp_resp    <= 2'b10;
            r_rsp_rdata   <= 32'd0;
            r_rsp_timeout <= 1'b1;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_ar_hs) r_ar_done <= 1'b1;
          if (w_r_hs) begin
            r_rsp_rdata <= AXI_rdata;
            r_rsp_resp  <= AXI_rresp;
          end
          if (!w_r_hs && w_limit) begin
            r_rsp_resp    <= 2'b10;
            r_rsp_rdata   <= 32'd0;
            r_rsp_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - randomized self-checking bench for axi_lite_master
module tb_axi_lite_master;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_master #(.TIMEOUT_CYCLES(T)) dut (
    .FCLK_CLK0(clk), .RST_N(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout),
    .AXI_awaddr(awaddr), .AXI_awprot(awprot), .AXI_awvalid(awvalid), .AXI_awready(awready),
    .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
    .AXI_araddr(araddr), .AXI_arprot(arprot), .AXI_arvalid(arvalid), .AXI_arready(arready),
    .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid), .AXI_rready(rready)
  );

  // Transaction model: phase 0 idle, 1 busy (cycle m_k), 2 response (cycle m_rk), 3 reset values.
  int          m_phase = 3;
  int          m_k, m_rk;
  bit          m_wr;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_br, m_rr;
  int          m_a, m_w, m_b, m_ar, m_r, m_nb;
  bit          m_to;
  bit          m_lit_en;
  int          m_lit_lat;
  logic [31:0] m_lit_rdata;
  logic [1:0]  m_lit_resp;
  bit          m_lit_to;

  int n_checks = 0;
  int n_fail = 0;
  int lat_cnt;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Completion cycle is the latest required handshake; beyond T-1 the master gives up after T cycles.
  function automatic void model_len();
    int c;
    c = m_wr ? imax(m_a, imax(m_w, m_b)) : imax(m_ar, m_r);
    m_to = (c > T - 1);
    m_nb = m_to ? T : c + 1;
  endfunction

  // Cycles from the accept cycle (counted as 1) to the first response cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lat_cnt <= 0;
    else if (cmd_valid && cmd_ready) lat_cnt <= 1;
    else if (!rsp_valid) lat_cnt <= lat_cnt + 1;
  end

  // Compare process: every cycle, DUT outputs against the model's phase.
  always @(negedge clk) begin
    case (m_phase)
      0: begin
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_axi", {awvalid, wvalid, bready, arvalid, rready}, 0);
      end
      1: begin
        chk("busy_cmd_ready", cmd_ready, 0);
        chk("busy_rsp_valid", rsp_valid, 0);
        chk("awvalid", awvalid, m_wr && (m_k <= m_a));
        chk("wvalid", wvalid, m_wr && (m_k <= m_w));
        chk("bready", bready, m_wr);
        chk("arvalid", arvalid, !m_wr && (m_k <= m_ar));
        chk("rready", rready, !m_wr);
        if (m_wr) begin
          chk("awaddr", awaddr, m_addr);
          chk("wdata", wdata, m_wdata);
          chk("wstrb", wstrb, m_wstrb);
          chk("awprot", awprot, 0);
        end else begin
          chk("araddr", araddr, m_addr);
          chk("arprot", arprot, 0);
        end
      end
      2: begin
        chk("resp_cmd_ready", cmd_ready, 0);
        chk("resp_rsp_valid", rsp_valid, 1);
        chk("resp_axi", {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("rsp_rdata", rsp_rdata, m_to ? 32'd0 : (m_wr ? 32'd0 : m_rd));
        chk("rsp_resp", rsp_resp, m_to ? 2'b10 : (m_wr ? m_br : m_rr));
        chk("rsp_timeout", rsp_timeout, m_to);
        if (m_lit_en && m_rk == 0) begin
          chk("lit_latency", lat_cnt, m_lit_lat);
          chk("lit_rdata", rsp_rdata, m_lit_rdata);
          chk("lit_resp", rsp_resp, m_lit_resp);
          chk("lit_timeout", rsp_timeout, m_lit_to);
        end
      end
      3: begin
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_axi", {awvalid, wvalid, bready, arvalid, rready, awprot, arprot, wstrb}, 0);
        chk("rst_addr", awaddr | araddr | wdata, 0);
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = 2'b00; rresp = 2'b00; rdata = 32'd0;
  endtask

  task automatic junk_cmd();
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
  endtask

  task automatic set_wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                        input int a, input int w, input int b, input logic [1:0] br);
    m_wr = 1; m_addr = addr; m_wdata = wd; m_wstrb = st;
    m_a = a; m_w = w; m_b = b; m_br = br; m_rr = 2'b00; m_rd = 32'd0;
    m_ar = 0; m_r = 0; m_lit_en = 0;
    model_len();
  endtask

  task automatic set_rd(input logic [31:0] addr, input int ar, input int r,
                        input logic [31:0] rd, input logic [1:0] rr);
    m_wr = 0; m_addr = addr; m_wdata = $urandom; m_wstrb = 4'($urandom);
    m_ar = ar; m_r = r; m_rd = rd; m_rr = rr; m_br = 2'b00;
    m_a = 0; m_w = 0; m_b = 0; m_lit_en = 0;
    model_len();
  endtask

  task automatic set_lit(input int lat, input logic [31:0] rd, input logic [1:0] rs, input bit to);
    m_lit_en = 1; m_lit_lat = lat; m_lit_rdata = rd; m_lit_resp = rs; m_lit_to = to;
  endtask

  task automatic do_accept();
    int gap;
    m_phase = 0;
    slave_idle();
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      cmd_valid = 1'b0; rsp_ready = 1'($urandom);
      tick();
    end
    cmd_valid = 1'b1; cmd_write = m_wr; cmd_addr = m_addr;
    cmd_wdata = m_wdata; cmd_wstrb = m_wstrb;
    tick();
    m_phase = 1;
  endtask

  // Scripted slave: readies rise at their offset and stay; B/R beats are
  // presented with decoy data on every cycle except the one that must be taken.
  task automatic do_busy(input int n);
    int rtake;
    rtake = imax(m_ar, m_r);
    for (int k = 0; k < n; k++) begin
      m_k = k;
      junk_cmd();
      rsp_ready = 1'($urandom);
      slave_idle();
      if (m_wr) begin
        awready = (k >= m_a);
        wready  = (k >= m_w);
        bvalid  = (k == m_b);
        bresp   = (k == m_b) ? m_br : ~m_br;
      end else begin
        arready = (k >= m_ar);
        rvalid  = (k >= m_r) && (k <= rtake);
        rdata   = (k == rtake) ? m_rd : ~m_rd;
        rresp   = (k == rtake) ? m_rr : ~m_rr;
      end
      tick();
    end
  endtask

  task automatic do_resp(input int delay);
    m_phase = 2;
    slave_idle();
    for (int i = 0; i < delay; i++) begin
      m_rk = i; rsp_ready = 1'b0; junk_cmd();
      tick();
    end
    m_rk = delay; rsp_ready = 1'b1; junk_cmd();
    tick();
    m_phase = 0;
    cmd_valid = 1'b0;
  endtask

  task automatic run_txn(input int delay);
    do_accept();
    do_busy(m_nb);
    do_resp(delay);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
    cmd_wdata = 32'd0; cmd_wstrb = 4'd0; rsp_ready = 1'b0;
    slave_idle();
    m_phase = 3;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Zero-wait write with combinational BVALID.
    set_wr(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00);
    set_lit(2, 32'd0, 2'b00, 0);
    run_txn(0);
    // Read with RVALID one cycle after RREADY.
    set_rd(32'h4, 0, 1, 32'h12345678, 2'b00);
    set_lit(3, 32'h12345678, 2'b00, 0);
    run_txn(0);
    // Staggered write channels, SLVERR response.
    set_wr(32'h10, 32'hA5A55A5A, 4'h3, 2, 5, 7, 2'b10);
    set_lit(9, 32'd0, 2'b10, 0);
    run_txn(1);
    // ARREADY never comes: abort after T cycles.
    set_rd(32'h20, 1000, 1000, 32'hCAFEF00D, 2'b00);
    set_lit(17, 32'd0, 2'b10, 1);
    run_txn(0);
    // Completion exactly on the limit cycle.
    set_wr(32'h24, 32'h01020304, 4'h8, 0, 3, T - 1, 2'b01);
    set_lit(T + 1, 32'd0, 2'b01, 0);
    run_txn(0);
    // Early RVALID before the address handshake is ignored.
    set_rd(32'h28, 4, 1, 32'h0BADC0DE, 2'b01);
    set_lit(6, 32'h0BADC0DE, 2'b01, 0);
    run_txn(0);
    // Response held back for 10 cycles, then another command.
    set_wr(32'h30, 32'h11223344, 4'h5, 0, 0, 1, 2'b00);
    run_txn(10);
    set_rd(32'h34, 0, 1, 32'h55667788, 2'b00);
    set_lit(3, 32'h55667788, 2'b00, 0);
    run_txn(0);

    // Reset in the middle of a write.
    set_wr(32'h40, 32'h99999999, 4'hF, 100, 100, 100, 2'b00);
    do_accept();
    do_busy(3);
    #2;
    rst_n = 1'b0;
    m_phase = 3;
    cmd_valid = 1'b0;
    slave_idle();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Randomized traffic, occasionally too slow to finish.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        set_wr($urandom, $urandom, 4'($urandom), $urandom_range(0, 6), $urandom_range(0, 6),
               ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 8), 2'($urandom));
      end else begin
        set_rd($urandom, ($urandom_range(0, 7) == 0) ? 25 : $urandom_range(0, 6),
               $urandom_range(0, 8), $urandom, 2'($urandom));
      end
      run_txn($urandom_range(0, 3));
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
